// File: rtl/clk_en_rate_monitor_if.sv
// rtl/clk_en_rate_monitor_if.sv - control/status bundle for the clock-enable rate monitor
interface clk_en_rate_monitor_if #(
  parameter int W = 16
);
  logic         en_i;
  logic         clk_en_i;
  logic [W-1:0] exp_period_i;
  logic         err_clr_i;
  logic [W-1:0] period_o;
  logic         period_vld_o;
  logic         locked_o;
  logic         err_o;
  logic [1:0]   err_code_o;

  modport master (
    output en_i, clk_en_i, exp_period_i, err_clr_i,
    input  period_o, period_vld_o, locked_o, err_o, err_code_o
  );

  modport slave (
    input  en_i, clk_en_i, exp_period_i, err_clr_i,
    output period_o, period_vld_o, locked_o, err_o, err_code_o
  );
endinterface

// File: rtl/clk_en_rate_monitor.sv
// rtl/clk_en_rate_monitor.sv - measures clk_en strobe spacing, locks on expected period, flags errors
module clk_en_rate_monitor #(
  parameter int W      = 16,
  parameter int LOCK_N = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  clk_en_rate_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_TO   = CNT_MAX - W'(1);
  localparam logic [7:0]   LOCK_N_C = LOCK_N[7:0];

  localparam logic [1:0] CODE_MISMATCH = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [7:0]   match_q, match_d;
  logic [W-1:0] period_q, period_d;
  logic         vld_q, vld_d;
  logic         locked_q, locked_d;
  logic         err_q, err_d;
  logic [1:0]   code_q, code_d;

  logic         err_set;
  logic [1:0]   err_new;
  logic [W-1:0] p_meas;
  logic         p_match;
  logic [7:0]   match_inc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    locked_d  = locked_q;
    err_set   = 1'b0;
    err_new   = 2'b00;
    p_meas    = cnt_q + W'(1);
    p_match   = (mon.exp_period_i != '0) && (p_meas == mon.exp_period_i);
    match_inc = match_q + 8'd1;

    if (!mon.en_i) begin
      // Dropping enable discards any interval in flight without reporting it
      state_d  = IDLE;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (mon.clk_en_i) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + W'(1);
          end
        end
        MEASURE, LOCKED: begin
          if (mon.clk_en_i) begin
            cnt_d    = '0;
            period_d = p_meas;
            vld_d    = 1'b1;
            if (state_q == MEASURE) begin
              if (p_match) begin
                match_d = match_inc;
                if (match_inc >= LOCK_N_C) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end else begin
                match_d = '0;
              end
            end else if (!p_match) begin
              // exp_period_i==0 disables checking: lock is lost but no error is raised
              state_d  = MEASURE;
              locked_d = 1'b0;
              match_d  = '0;
              if (mon.exp_period_i != '0) begin
                err_set = 1'b1;
                err_new = CODE_MISMATCH;
              end
            end
          end else if (cnt_q == CNT_TO) begin
            cnt_d    = CNT_MAX;
            state_d  = ARM;
            locked_d = 1'b0;
            match_d  = '0;
            err_set  = 1'b1;
            err_new  = CODE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // First error is kept while sticky; a clear in the same cycle lets the new code through
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (err_set) begin
      err_d  = 1'b1;
      code_d = (err_q && !mon.err_clr_i) ? code_q : err_new;
    end else if (mon.err_clr_i) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  assign mon.period_o     = period_q;
  assign mon.period_vld_o = vld_q;
  assign mon.locked_o     = locked_q;
  assign mon.err_o        = err_q;
  assign mon.err_code_o   = code_q;

endmodule

// File: tb/tb_clk_en_rate_monitor.sv
// tb/tb_clk_en_rate_monitor.sv - scoreboard bench for clk_en_rate_monitor
module tb_clk_en_rate_monitor;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] period;
    logic         locked;
    logic         err;
    logic [1:0]   code;
  } exp_t;

  logic clk_i;
  logic rstn_i;
  int   checks;
  int   fails;
  exp_t exp_q[$];

  clk_en_rate_monitor_if #(.W(W)) bus ();

  clk_en_rate_monitor #(.W(W), .LOCK_N(4)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .mon    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step(input logic s);
    bus.clk_en_i = s;
    @(negedge clk_i);
  endtask

  // n-1 idle cycles then a strobe; the strobe's report is queued for the monitor
  task automatic gap(input int n, input logic clr, input logic lk, input logic er, input logic [1:0] cd);
    exp_t e;
    for (int i = 1; i < n; i++) step(1'b0);
    e.period = W'(n);
    e.locked = lk;
    e.err    = er;
    e.code   = cd;
    exp_q.push_back(e);
    bus.err_clr_i = clr;
    step(1'b1);
    bus.err_clr_i = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic lk, input logic er, input logic [1:0] cd);
    check({tag, "_locked"}, 32'(bus.locked_o), 32'(lk));
    check({tag, "_err"}, 32'(bus.err_o), 32'(er));
    check({tag, "_code"}, 32'(bus.err_code_o), 32'(cd));
  endtask

  always @(negedge clk_i) begin
    if (rstn_i && bus.period_vld_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 32'(bus.period_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_period", 32'(bus.period_o), 32'(e.period));
        check("sb_locked", 32'(bus.locked_o), 32'(e.locked));
        check("sb_err", 32'(bus.err_o), 32'(e.err));
        check("sb_code", 32'(bus.err_code_o), 32'(e.code));
      end
    end
  end

  initial begin
    checks = 0;
    fails  = 0;
    rstn_i = 1'b0;
    bus.en_i = 1'b0;
    bus.clk_en_i = 1'b0;
    bus.exp_period_i = '0;
    bus.err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_period", 32'(bus.period_o), 32'h0);
    check("rst_vld", 32'(bus.period_vld_o), 32'h0);
    check_status("rst", 1'b0, 1'b0, 2'b00);
    rstn_i = 1'b1;
    step(1'b0);

    // lock at exp=4
    bus.exp_period_i = 4'd4;
    bus.en_i = 1'b1;
    step(1'b0);
    step(1'b1);
    gap(4, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(4, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(4, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(4, 1'b0, 1'b1, 1'b0, 2'b00);

    // mismatch after lock, then relock with sticky error
    gap(5, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(4, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(4, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(4, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(4, 1'b0, 1'b1, 1'b1, 2'b01);

    // clear on a matching strobe, then expected period changes while locked
    gap(4, 1'b1, 1'b1, 1'b0, 2'b00);
    bus.exp_period_i = 4'd3;
    gap(3, 1'b0, 1'b1, 1'b0, 2'b00);

    // timeout: cnt reaches 15 after 15 strobe-free cycles
    repeat (14) step(1'b0);
    check_status("pre_timeout", 1'b1, 1'b0, 2'b00);
    step(1'b0);
    check_status("timeout", 1'b0, 1'b1, 2'b10);

    // ARM: first strobe only restarts, then relock at 3
    step(1'b1);
    gap(3, 1'b0, 1'b0, 1'b1, 2'b10);
    gap(3, 1'b0, 1'b0, 1'b1, 2'b10);
    gap(3, 1'b0, 1'b0, 1'b1, 2'b10);
    gap(3, 1'b0, 1'b1, 1'b1, 2'b10);

    // clear racing a new mismatch: new code wins
    gap(5, 1'b1, 1'b0, 1'b1, 2'b01);

    // back-to-back strobes with exp=1
    bus.exp_period_i = 4'd1;
    gap(1, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(1, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(1, 1'b0, 1'b0, 1'b1, 2'b01);
    gap(1, 1'b0, 1'b1, 1'b1, 2'b01);

    // enable falls: lock drops, period and error hold, strobes ignored
    bus.en_i = 1'b0;
    step(1'b0);
    check_status("en_off", 1'b0, 1'b1, 2'b01);
    check("en_off_period", 32'(bus.period_o), 32'h1);
    step(1'b1);
    step(1'b1);
    bus.err_clr_i = 1'b1;
    step(1'b0);
    bus.err_clr_i = 1'b0;
    check_status("clr_idle", 1'b0, 1'b0, 2'b00);

    // exp=0: measurement only
    bus.exp_period_i = 4'd0;
    bus.en_i = 1'b1;
    step(1'b0);
    step(1'b1);
    gap(2, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(3, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(1, 1'b0, 1'b0, 1'b0, 2'b00);
    gap(1, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0);
    check_status("exp0", 1'b0, 1'b0, 2'b00);

    // asynchronous reset mid-run
    rstn_i = 1'b0;
    #1;
    check("arst_period", 32'(bus.period_o), 32'h0);
    check_status("arst", 1'b0, 1'b0, 2'b00);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(1'b1);
    step(1'b1);
    check("post_rst_vld", 32'(bus.period_vld_o), 32'h0);
    check("post_rst_period", 32'(bus.period_o), 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
